regfile_port_arbiter: RTL and testbench



---
 rtl/regfile_arb_pkg.sv | 26 ++
 rtl/regfile_port_arbiter_if.sv | 62 ++++++
 rtl/regfile_tag_queue.sv | 52 +++++
 rtl/regfile_port_arbiter.sv | 87 ++++++++
 tb/tb_regfile_port_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types for the two-client register-file port arbiter.
// A tag records who owns each entry the register file is holding, so its read response can be routed.
package regfile_arb_pkg;

    localparam int TAG_DEPTH = 2;
    localparam int TAG_IDX_W = 5;

    typedef struct packed {
        logic                 client;
        logic                 discard;
        logic [TAG_IDX_W-1:0] index;
    } tag_t;

    // The register file comes out of reset holding one entry at index 0 that nobody asked for.
    localparam tag_t TAG_RESET = '{client: 1'b0, discard: 1'b1, index: '0};

    function automatic tag_t make_tag(input logic client, input logic discard,
                                      input logic [TAG_IDX_W-1:0] index);
        tag_t t;
        t.client  = client;
        t.discard = discard;
        t.index   = index;
        return t;
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Client and register-file handshake signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding clients plus register file.
interface regfile_port_arbiter_if #(
    parameter int width = 32,
    parameter int n     = 5
);
    logic             REQ0_VALID;
    logic             REQ1_VALID;
    logic             REQ0_WRITE;
    logic             REQ1_WRITE;
    logic [n-1:0]     REQ0_INDEX;
    logic [n-1:0]     REQ1_INDEX;
    logic [width-1:0] REQ0_DATA;
    logic [width-1:0] REQ1_DATA;
    logic             REQ0_CONSUMED;
    logic             REQ1_CONSUMED;

    logic [width-1:0] RESP0_DATA;
    logic [width-1:0] RESP1_DATA;
    logic             RESP0_VALID;
    logic             RESP1_VALID;
    logic             RESP0_CONSUMED;
    logic             RESP1_CONSUMED;

    logic             RF_WRITE_EN;
    logic [n-1:0]     RF_WRITE_INDEX;
    logic [width-1:0] RF_WRITE_DATA;
    logic             RF_WRITE_VALID;
    logic             RF_WRITE_CONSUMED;
    logic [n-1:0]     RF_READ_REQ;
    logic             RF_READ_REQ_VALID;
    logic [width-1:0] RF_READ_RESP;
    logic             RF_READ_RESP_VALID;
    logic             RF_READ_RESP_CONSUMED;

    modport slave (
        input  REQ0_VALID, REQ1_VALID, REQ0_WRITE, REQ1_WRITE,
        input  REQ0_INDEX, REQ1_INDEX, REQ0_DATA, REQ1_DATA,
        output REQ0_CONSUMED, REQ1_CONSUMED,
        output RESP0_DATA, RESP1_DATA, RESP0_VALID, RESP1_VALID,
        input  RESP0_CONSUMED, RESP1_CONSUMED,
        output RF_WRITE_EN, RF_WRITE_INDEX, RF_WRITE_DATA, RF_WRITE_VALID,
        input  RF_WRITE_CONSUMED,
        output RF_READ_REQ, RF_READ_REQ_VALID,
        input  RF_READ_RESP, RF_READ_RESP_VALID,
        output RF_READ_RESP_CONSUMED
    );

    modport master (
        output REQ0_VALID, REQ1_VALID, REQ0_WRITE, REQ1_WRITE,
        output REQ0_INDEX, REQ1_INDEX, REQ0_DATA, REQ1_DATA,
        input  REQ0_CONSUMED, REQ1_CONSUMED,
        input  RESP0_DATA, RESP1_DATA, RESP0_VALID, RESP1_VALID,
        output RESP0_CONSUMED, RESP1_CONSUMED,
        input  RF_WRITE_EN, RF_WRITE_INDEX, RF_WRITE_DATA, RF_WRITE_VALID,
        output RF_WRITE_CONSUMED,
        input  RF_READ_REQ, RF_READ_REQ_VALID,
        output RF_READ_RESP, RF_READ_RESP_VALID,
        input  RF_READ_RESP_CONSUMED
    );

endinterface

// File: rtl/regfile_tag_queue.sv
// Two-entry tag FIFO, head visible combinationally; push and pop may coincide in one cycle.
// Pushes are dropped when full unless a pop frees the slot in the same cycle.
module regfile_tag_queue
    import regfile_arb_pkg::*;
#(
    parameter bit   FILL_EN  = 1'b1,
    parameter tag_t FILL_TAG = TAG_RESET
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       i_push,
    input  tag_t       i_push_tag,
    input  logic       i_pop,
    output tag_t       o_head,
    output logic [1:0] o_count
);

    tag_t       r_ent [TAG_DEPTH];
    logic [1:0] r_count;
    logic       w_pop;
    logic       w_push;
    logic       w_slot;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);
    // Slot the new tag lands in once the head (if popping) has shifted down.
    assign w_slot = r_count[0] ^ w_pop;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_ent[0] <= FILL_TAG;
            r_ent[1] <= '0;
            r_count  <= FILL_EN ? 2'd1 : 2'd0;
        end else begin
            if (w_pop) begin
                r_ent[0] <= r_ent[1];
            end
            if (w_push) begin
                r_ent[w_slot] <= i_push_tag;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_head  = r_ent[0];
    assign o_count = r_count;

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin share of one register-file port between two clients; requests accepted same cycle.
// Issue stalls while two entries are in flight or the write channel is busy; responses wait on their owner.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int width = 32,
    parameter int n     = 5
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    regfile_port_arbiter_if.slave bus
);

    logic             r_rr;
    logic             w_any;
    logic             w_gnt;
    logic             w_room;
    logic             w_issue;
    logic             w_wr_en;
    logic [n-1:0]     w_wr_idx;
    logic [width-1:0] w_wr_dat;
    logic [1:0]       w_count;
    tag_t             w_head;
    tag_t             w_push_tag;
    logic             w_head_live;
    logic             w_owner_take;
    logic             w_rsp_take;
    logic             w_pop;

    // Grant: with both asking, the client not served last wins; otherwise whoever asks.
    assign w_any   = bus.REQ0_VALID || bus.REQ1_VALID;
    assign w_gnt   = (bus.REQ0_VALID && bus.REQ1_VALID) ? ~r_rr : bus.REQ1_VALID;
    assign w_room  = RST_N && (w_count != 2'd2);
    assign w_issue = w_any && w_room && bus.RF_WRITE_CONSUMED;

    assign w_wr_en  = w_gnt ? bus.REQ1_WRITE : bus.REQ0_WRITE;
    assign w_wr_idx = w_gnt ? bus.REQ1_INDEX : bus.REQ0_INDEX;
    assign w_wr_dat = w_gnt ? bus.REQ1_DATA  : bus.REQ0_DATA;

    assign bus.RF_WRITE_VALID = w_any && w_room;
    assign bus.RF_WRITE_EN    = w_wr_en;
    assign bus.RF_WRITE_INDEX = w_wr_idx;
    assign bus.RF_WRITE_DATA  = w_wr_dat;
    assign bus.REQ0_CONSUMED  = w_issue && !w_gnt;
    assign bus.REQ1_CONSUMED  = w_issue && w_gnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rr <= 1'b1;
        end else if (w_issue) begin
            r_rr <= w_gnt;
        end
    end

    // Writes still produce a read response from the register file; tag them so it is thrown away.
    assign w_push_tag = make_tag(w_gnt, w_wr_en, TAG_IDX_W'(w_wr_idx));

    regfile_tag_queue #(
        .FILL_EN  (1'b1),
        .FILL_TAG (TAG_RESET)
    ) u_tag_queue (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .i_push     (w_issue),
        .i_push_tag (w_push_tag),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    assign w_head_live  = RST_N && (w_count != 2'd0);
    assign w_owner_take = w_head.client ? bus.RESP1_CONSUMED : bus.RESP0_CONSUMED;
    assign w_rsp_take   = w_head_live && (w_head.discard || w_owner_take);
    assign w_pop        = bus.RF_READ_RESP_VALID && w_rsp_take;

    assign bus.RF_READ_REQ           = n'(w_head.index);
    assign bus.RF_READ_REQ_VALID     = w_head_live;
    assign bus.RF_READ_RESP_CONSUMED = w_rsp_take;

    assign bus.RESP0_DATA  = bus.RF_READ_RESP;
    assign bus.RESP1_DATA  = bus.RF_READ_RESP;
    assign bus.RESP0_VALID = w_head_live && !w_head.discard && !w_head.client
                             && bus.RF_READ_RESP_VALID;
    assign bus.RESP1_VALID = w_head_live && !w_head.discard && w_head.client
                             && bus.RF_READ_RESP_VALID;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a combinational register-file model.
module tb_regfile_port_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        rf_load;
    logic        rf_wr_rdy;
    logic        rf_rd_rdy;
    logic [31:0] arr [32];
    int          errors;
    int          checks;

    regfile_port_arbiter_if #(.width(32), .n(5)) bus ();

    regfile_port_arbiter #(.width(32), .n(5)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Register-file model: write on accepted entry, read data presented for the current read index.
    always @(posedge CLK) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) arr[i] <= 32'h1000 + i;
            arr[3] <= 32'hAB;
        end else if (bus.RF_WRITE_VALID && bus.RF_WRITE_CONSUMED && bus.RF_WRITE_EN) begin
            arr[bus.RF_WRITE_INDEX] <= bus.RF_WRITE_DATA;
        end
    end
    assign bus.RF_WRITE_CONSUMED  = rf_wr_rdy;
    assign bus.RF_READ_RESP       = arr[bus.RF_READ_REQ];
    assign bus.RF_READ_RESP_VALID = bus.RF_READ_REQ_VALID && rf_rd_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic req0(input logic v, input logic w, input logic [4:0] idx, input logic [31:0] d);
        bus.REQ0_VALID = v; bus.REQ0_WRITE = w; bus.REQ0_INDEX = idx; bus.REQ0_DATA = d;
    endtask

    task automatic req1(input logic v, input logic w, input logic [4:0] idx, input logic [31:0] d);
        bus.REQ1_VALID = v; bus.REQ1_WRITE = w; bus.REQ1_INDEX = idx; bus.REQ1_DATA = d;
    endtask

    task automatic do_reset(input logic load);
        RST_N   = 1'b0;
        rf_load = load;
        req0(1'b0, 1'b0, 5'd0, 32'h0);
        req1(1'b0, 1'b0, 5'd0, 32'h0);
        next_cycle();
        next_cycle();
        RST_N   = 1'b1;
        rf_load = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rf_wr_rdy = 1'b1;
        rf_rd_rdy = 1'b1;
        bus.RESP0_CONSUMED = 1'b1;
        bus.RESP1_CONSUMED = 1'b1;
        RST_N   = 1'b0;
        rf_load = 1'b1;
        req0(1'b1, 1'b0, 5'd3, 32'h0);
        req1(1'b0, 1'b0, 5'd0, 32'h0);
        next_cycle();
        chk("rst_req0_consumed", 32'(bus.REQ0_CONSUMED), 32'd0);
        chk("rst_resp0_valid", 32'(bus.RESP0_VALID), 32'd0);
        chk("rst_wr_valid", 32'(bus.RF_WRITE_VALID), 32'd0);
        do_reset(1'b1);

        // Client 0 reads index 3 while the pre-loaded entry drains.
        req0(1'b1, 1'b0, 5'd3, 32'h0);
        #1;
        chk("t1_count", 32'(dut.w_count), 32'd1);
        chk("t1_rdreq_idx", 32'(bus.RF_READ_REQ), 32'd0);
        chk("t1_drop_consumed", 32'(bus.RF_READ_RESP_CONSUMED), 32'd1);
        chk("t1_resp0_valid_pre", 32'(bus.RESP0_VALID), 32'd0);
        chk("t1_req0_consumed", 32'(bus.REQ0_CONSUMED), 32'd1);
        chk("t1_wr_en", 32'(bus.RF_WRITE_EN), 32'd0);
        chk("t1_wr_idx", 32'(bus.RF_WRITE_INDEX), 32'd3);
        next_cycle();
        req0(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("t1_resp0_valid", 32'(bus.RESP0_VALID), 32'd1);
        chk("t1_resp0_data", bus.RESP0_DATA, 32'hAB);
        chk("t1_resp1_valid", 32'(bus.RESP1_VALID), 32'd0);
        next_cycle();
        #1;
        chk("t1_count_empty", 32'(dut.w_count), 32'd0);
        chk("t1_rdreq_valid", 32'(bus.RF_READ_REQ_VALID), 32'd0);

        // Both clients read every cycle: grants alternate starting with client 0.
        do_reset(1'b0);
        for (int k = 0; k < 7; k++) begin
            if (k < 6) begin
                req0(1'b1, 1'b0, 5'(8 + k), 32'h0);
                req1(1'b1, 1'b0, 5'(8 + k), 32'h0);
            end else begin
                req0(1'b0, 1'b0, 5'd0, 32'h0);
                req1(1'b0, 1'b0, 5'd0, 32'h0);
            end
            #1;
            if (k < 6) begin
                chk("t2_gnt0", 32'(bus.REQ0_CONSUMED), (k % 2 == 0) ? 32'd1 : 32'd0);
                chk("t2_gnt1", 32'(bus.REQ1_CONSUMED), (k % 2 == 1) ? 32'd1 : 32'd0);
            end
            if (k == 0) begin
                chk("t2_resp0_none", 32'(bus.RESP0_VALID), 32'd0);
                chk("t2_resp1_none", 32'(bus.RESP1_VALID), 32'd0);
            end else begin
                chk("t2_resp0_valid", 32'(bus.RESP0_VALID), ((k - 1) % 2 == 0) ? 32'd1 : 32'd0);
                chk("t2_resp1_valid", 32'(bus.RESP1_VALID), ((k - 1) % 2 == 1) ? 32'd1 : 32'd0);
                chk("t2_resp_data", bus.RF_READ_RESP, 32'h1000 + 32'(8 + k - 1));
            end
            next_cycle();
        end

        // Client 1 writes 0x55 to index 7, client 0 reads it back next cycle.
        req1(1'b1, 1'b1, 5'd7, 32'h55);
        #1;
        chk("t3_req1_consumed", 32'(bus.REQ1_CONSUMED), 32'd1);
        chk("t3_wr_en", 32'(bus.RF_WRITE_EN), 32'd1);
        chk("t3_wr_data", bus.RF_WRITE_DATA, 32'h55);
        next_cycle();
        req1(1'b0, 1'b0, 5'd0, 32'h0);
        req0(1'b1, 1'b0, 5'd7, 32'h0);
        #1;
        chk("t3_wr_resp_dropped", 32'(bus.RESP1_VALID), 32'd0);
        chk("t3_req0_consumed", 32'(bus.REQ0_CONSUMED), 32'd1);
        next_cycle();
        req0(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("t3_resp0_valid", 32'(bus.RESP0_VALID), 32'd1);
        chk("t3_resp0_data", bus.RESP0_DATA, 32'h55);
        chk("t3_resp1_valid", 32'(bus.RESP1_VALID), 32'd0);
        next_cycle();

        // Client 0 stalls its responses until two tags fill the queue.
        bus.RESP0_CONSUMED = 1'b0;
        req0(1'b1, 1'b0, 5'd1, 32'h0);
        next_cycle();
        req0(1'b1, 1'b0, 5'd2, 32'h0);
        #1;
        chk("t4_second_issue", 32'(bus.REQ0_CONSUMED), 32'd1);
        next_cycle();
        req0(1'b1, 1'b0, 5'd4, 32'h0);
        req1(1'b1, 1'b0, 5'd5, 32'h0);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t4_full_count", 32'(dut.w_count), 32'd2);
            chk("t4_full_req0", 32'(bus.REQ0_CONSUMED), 32'd0);
            chk("t4_full_req1", 32'(bus.REQ1_CONSUMED), 32'd0);
            chk("t4_full_wr_valid", 32'(bus.RF_WRITE_VALID), 32'd0);
            chk("t4_hold_resp0", bus.RESP0_DATA, 32'h1001);
            next_cycle();
        end
        bus.RESP0_CONSUMED = 1'b1;
        #1;
        chk("t4_pop_no_issue", 32'(bus.REQ0_CONSUMED | bus.REQ1_CONSUMED), 32'd0);
        chk("t4_pop_valid", 32'(bus.RESP0_VALID), 32'd1);
        next_cycle();
        #1;
        chk("t5_count_one", 32'(dut.w_count), 32'd1);
        chk("t5_resp0_data", bus.RESP0_DATA, 32'h1002);
        chk("t5_issue_req1", 32'(bus.REQ1_CONSUMED), 32'd1);
        chk("t5_issue_req0", 32'(bus.REQ0_CONSUMED), 32'd0);
        next_cycle();
        req1(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("t5_count_kept", 32'(dut.w_count), 32'd1);
        chk("t5_resp1_valid", 32'(bus.RESP1_VALID), 32'd1);
        chk("t5_resp1_data", bus.RESP1_DATA, 32'h1005);
        chk("t5_waiter_req0", 32'(bus.REQ0_CONSUMED), 32'd1);
        next_cycle();
        req0(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("t5_resp0_valid", 32'(bus.RESP0_VALID), 32'd1);
        chk("t5_resp0_data4", bus.RESP0_DATA, 32'h1004);
        next_cycle();

        // Reset with two reads outstanding.
        bus.RESP0_CONSUMED = 1'b0;
        req0(1'b1, 1'b0, 5'd6, 32'h0);
        next_cycle();
        req0(1'b1, 1'b0, 5'd9, 32'h0);
        next_cycle();
        #1;
        chk("t6_count_full", 32'(dut.w_count), 32'd2);
        RST_N = 1'b0;
        #1;
        chk("t6_rst_req0", 32'(bus.REQ0_CONSUMED), 32'd0);
        chk("t6_rst_resp0", 32'(bus.RESP0_VALID), 32'd0);
        next_cycle();
        RST_N = 1'b1;
        bus.RESP0_CONSUMED = 1'b1;
        req0(1'b1, 1'b0, 5'd6, 32'h0);
        req1(1'b1, 1'b0, 5'd9, 32'h0);
        #1;
        chk("t6_count_reset", 32'(dut.w_count), 32'd1);
        chk("t6_rdreq_idx", 32'(bus.RF_READ_REQ), 32'd0);
        chk("t6_resp0_none", 32'(bus.RESP0_VALID), 32'd0);
        chk("t6_rr_req0", 32'(bus.REQ0_CONSUMED), 32'd1);
        chk("t6_rr_req1", 32'(bus.REQ1_CONSUMED), 32'd0);
        next_cycle();
        req0(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("t6_resp0_valid", 32'(bus.RESP0_VALID), 32'd1);
        chk("t6_resp0_data", bus.RESP0_DATA, 32'h1006);
        chk("t6_req1_issue", 32'(bus.REQ1_CONSUMED), 32'd1);
        next_cycle();
        req1(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("t6_resp1_valid", 32'(bus.RESP1_VALID), 32'd1);
        chk("t6_resp1_data", bus.RESP1_DATA, 32'h1009);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
